// File: rtl/mix_cols_engine_pkg.sv
// AES shared types and GF(2^8) helpers for the
// MixColumns / InvMixColumns engine.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_COL_W   = 32;

  typedef enum logic {
    MIX_FWD = 1'b0,
    MIX_INV = 1'b1
  } mix_mode_e;

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // coef is at most 4 bits wide: MixColumns only needs 01..0e
  function automatic logic [7:0] gf_mul(
    input logic [7:0] b,
    input logic [3:0] coef
  );
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{coef[0]}} & b)
         ^ ({8{coef[1]}} & x2)
         ^ ({8{coef[2]}} & x4)
         ^ ({8{coef[3]}} & x8);
  endfunction

endpackage

// File: rtl/mix_cols_engine_if.sv
// Producer/consumer handshake bundle for the
// MixColumns engine.
interface mix_cols_engine_if;
  import aes_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic                   mode;
  logic [AES_BLOCK_W-1:0] data_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_BLOCK_W-1:0] data_out;

  modport master (
    output in_valid,
    output mode,
    output data_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  data_out
  );

  modport slave (
    input  in_valid,
    input  mode,
    input  data_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output data_out
  );

endinterface

// File: rtl/mix_cols_engine_mix_single_column.sv
// Combinational transform of one 32-bit column,
// forward or inverse MixColumns.
module mix_single_column
  import aes_pkg::*;
(
  input  mix_mode_e              mode_i,
  input  logic [AES_COL_W-1:0]   col_i,
  output logic [AES_COL_W-1:0]   col_o
);

  logic [7:0] a [4];
  logic [3:0] k [4];
  logic [7:0] acc;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a[i] = col_i[31-8*i -: 8];
    end
    if (mode_i == MIX_INV) begin
      k[0] = 4'he;
      k[1] = 4'hb;
      k[2] = 4'hd;
      k[3] = 4'h9;
    end else begin
      k[0] = 4'h2;
      k[1] = 4'h3;
      k[2] = 4'h1;
      k[3] = 4'h1;
    end
    col_o = '0;
    acc   = '0;
    // row r uses the coefficient vector rotated right by r
    for (int r = 0; r < 4; r++) begin
      acc = '0;
      for (int j = 0; j < 4; j++) begin
        acc = acc ^ gf_mul(a[j], k[(j - r + 4) % 4]);
      end
      col_o[31-8*r -: 8] = acc;
    end
  end

endmodule

// File: rtl/mix_cols_engine.sv
// Round-pipeline MixColumns/InvMixColumns engine,
// COLS_PER_CYCLE columns per clock, valid/ready both sides.
module mix_cols_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  mix_cols_engine_if.slave io,
  output logic             busy
);

  localparam int C = COLS_PER_CYCLE;
  localparam int N = 4 / C;

  if (!(C == 1 || C == 2 || C == 4)) begin : g_bad_cfg
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [AES_BLOCK_W-1:0] data_q, data_d;
  logic [AES_BLOCK_W-1:0] out_q, out_d;
  mix_mode_e              mode_q, mode_d;

  logic                   accept;
  logic                   last;
  logic [AES_BLOCK_W-1:0] mixed;
  logic [AES_COL_W-1:0]   cols       [4];
  logic [AES_COL_W-1:0]   mixed_cols [4];
  logic [AES_COL_W-1:0]   col_in     [C];
  logic [AES_COL_W-1:0]   col_out    [C];
  logic [1:0]             col_idx    [C];

  for (genvar c = 0; c < 4; c++) begin : g_split
    assign cols[c] = data_q[127-32*c -: 32];
  end

  for (genvar i = 0; i < C; i++) begin : g_lane
    localparam logic [1:0] LANE = 2'(i);
    assign col_idx[i] = (C == 1) ? cnt_q :
                        (C == 2) ? {cnt_q[0], LANE[0]} :
                                   LANE;
    assign col_in[i]  = cols[col_idx[i]];

    mix_single_column u_col (
      .mode_i (mode_q),
      .col_i  (col_in[i]),
      .col_o  (col_out[i])
    );
  end

  // columns not touched this cycle pass through unchanged
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      mixed_cols[c] = cols[c];
    end
    for (int i = 0; i < C; i++) begin
      mixed_cols[col_idx[i]] = col_out[i];
    end
    mixed = {mixed_cols[0], mixed_cols[1],
             mixed_cols[2], mixed_cols[3]};
  end

  assign io.in_ready  = (state_q == S_IDLE) ||
                        (state_q == S_DONE && io.out_ready);
  assign io.out_valid = (state_q == S_DONE);
  assign io.data_out  = out_q;
  assign busy         = (state_q == S_BUSY);

  assign accept = io.in_valid && io.in_ready;
  assign last   = (cnt_q == 2'(N - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mode_d  = mode_q;
    out_d   = out_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_BUSY;
          cnt_d   = '0;
          data_d  = io.data_in;
          mode_d  = mix_mode_e'(io.mode);
        end
      end
      S_BUSY: begin
        data_d = mixed;
        if (last) begin
          state_d = S_DONE;
          cnt_d   = '0;
          out_d   = mixed;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_DONE: begin
        if (accept) begin
          state_d = S_BUSY;
          cnt_d   = '0;
          data_d  = io.data_in;
          mode_d  = mix_mode_e'(io.mode);
        end else if (io.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      out_q   <= '0;
      mode_q  <= MIX_FWD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      out_q   <= out_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_mix_cols_engine.sv
// Directed + round-trip bench for mix_cols_engine
// at COLS_PER_CYCLE = 4, 2 and 1.
module tb_mix_cols_engine;
  import aes_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid;
  logic         mode;
  logic         out_ready;
  logic [127:0] data_in;
  int           sel;

  logic         busy4, busy2, busy1;
  logic         in_ready_m, out_valid_m, busy_m;
  logic [127:0] data_out_m;

  int checks = 0;
  int errors = 0;

  mix_cols_engine_if if4 ();
  mix_cols_engine_if if2 ();
  mix_cols_engine_if if1 ();

  assign if4.in_valid  = in_valid && sel == 0;
  assign if4.out_ready = out_ready && sel == 0;
  assign if4.mode      = mode;
  assign if4.data_in   = data_in;
  assign if2.in_valid  = in_valid && sel == 1;
  assign if2.out_ready = out_ready && sel == 1;
  assign if2.mode      = mode;
  assign if2.data_in   = data_in;
  assign if1.in_valid  = in_valid && sel == 2;
  assign if1.out_ready = out_ready && sel == 2;
  assign if1.mode      = mode;
  assign if1.data_in   = data_in;

  mix_cols_engine #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk (clk), .rst (rst), .io (if4.slave), .busy (busy4)
  );
  mix_cols_engine #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk (clk), .rst (rst), .io (if2.slave), .busy (busy2)
  );
  mix_cols_engine #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk (clk), .rst (rst), .io (if1.slave), .busy (busy1)
  );

  always_comb begin
    in_ready_m  = if4.in_ready;
    out_valid_m = if4.out_valid;
    data_out_m  = if4.data_out;
    busy_m      = busy4;
    case (sel)
      1: begin
        in_ready_m  = if2.in_ready;
        out_valid_m = if2.out_valid;
        data_out_m  = if2.data_out;
        busy_m      = busy2;
      end
      2: begin
        in_ready_m  = if1.in_ready;
        out_valid_m = if1.out_valid;
        data_out_m  = if1.data_out;
        busy_m      = busy1;
      end
      default: ;
    endcase
  end

  task automatic chk(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // shift-and-add multiply, independent of the RTL's xtime chain
  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? (8'(x << 1) ^ 8'h1b) : 8'(x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(
    input logic [127:0] s,
    input logic         m
  );
    logic [7:0] fm [4][4] = '{'{8'h02, 8'h03, 8'h01, 8'h01},
                              '{8'h01, 8'h02, 8'h03, 8'h01},
                              '{8'h01, 8'h01, 8'h02, 8'h03},
                              '{8'h03, 8'h01, 8'h01, 8'h02}};
    logic [7:0] im [4][4] = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09},
                              '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                              '{8'h0d, 8'h09, 8'h0e, 8'h0b},
                              '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
    logic [127:0] res = '0;
    logic [7:0]   acc;
    logic [7:0]   cf;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          cf  = m ? im[r][j] : fm[r][j];
          acc = acc ^ gmul(cf, s[127-32*c-8*j -: 8]);
        end
        res[127-32*c-8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  task automatic send(
    input logic         m,
    input logic [127:0] d
  );
    int n = 0;
    @(negedge clk);
    data_in  = d;
    mode     = m;
    in_valid = 1'b1;
    while (!in_ready_m && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 128'(in_ready_m), 128'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_in  = ~d;
    mode     = ~m;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid_m && lat < 40);
  endtask

  task automatic take(output logic [127:0] r);
    r         = data_out_m;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic txn(
    input  logic         m,
    input  logic [127:0] d,
    output logic [127:0] r,
    output int           lat
  );
    send(m, d);
    wait_done(lat);
    chk("txn_valid", 128'(out_valid_m), 128'(1));
    take(r);
  endtask

  logic [127:0] r, f, held, a_st, b_st, d;
  int           lat;
  logic         flag;

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    mode      = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    sel       = 0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_out_valid", 128'(out_valid_m), 128'(0));
      chk("rst_busy", 128'(busy_m), 128'(0));
      chk("rst_data_out", data_out_m, 128'(0));
    end
    sel = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_in_ready", 128'(in_ready_m), 128'(1));

    sel = 0;
    txn(1'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5, r, lat);
    chk("fwd_c4", r, 128'h046681e5e0cb199a48f8d37a2806264c);
    chk("fwd_c4_lat", 128'(lat), 128'(1));

    txn(1'b0, 128'hdb135345f20a225c01010101c6c6c6c6, r, lat);
    chk("col_id_a", r, 128'h8e4da1bc9fdc589d01010101c6c6c6c6);
    txn(1'b0, 128'hd4d4d4d52d26314c01010101c6c6c6c6, r, lat);
    chk("col_id_b", r, 128'hd5d5d7d64d7ebdf801010101c6c6c6c6);

    sel = 1;
    txn(1'b1, 128'h8e4da1bc9fdc589d01010101c6c6c6c6, r, lat);
    chk("inv_c2_a", r, 128'hdb135345f20a225c01010101c6c6c6c6);
    chk("inv_c2_lat", 128'(lat), 128'(2));
    txn(1'b1, 128'hd5d5d7d64d7ebdf801010101c6c6c6c6, r, lat);
    chk("inv_c2_b", r, 128'hd4d4d4d52d26314c01010101c6c6c6c6);

    sel = 2;
    txn(1'b1, 128'h046681e5e0cb199a48f8d37a2806264c, r, lat);
    chk("inv_c1", r, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    chk("inv_c1_lat", 128'(lat), 128'(4));

    // backpressure then same-edge retire and accept
    sel  = 1;
    a_st = 128'h0123456789abcdeffedcba9876543210;
    b_st = 128'h00112233445566778899aabbccddeeff;
    send(1'b0, a_st);
    wait_done(lat);
    chk("bp_lat", 128'(lat), 128'(2));
    held = data_out_m;
    chk("bp_data", held, ref_mix(a_st, 1'b0));
    in_valid = 1'b1;
    data_in  = b_st;
    mode     = 1'b1;
    flag     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (data_out_m !== held || !out_valid_m || in_ready_m)
        flag = 1'b0;
    end
    chk("bp_stable", 128'(flag), 128'(1));
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready", 128'(in_ready_m), 128'(1));
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    @(negedge clk);
    chk("bp_no_bubble", 128'(busy_m), 128'(1));
    chk("bp_retired", 128'(out_valid_m), 128'(0));
    wait_done(lat);
    chk("b2b_lat", 128'(lat), 128'(2));
    take(r);
    chk("b2b_data", r, ref_mix(b_st, 1'b1));

    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int n = 0; n < 1000; n++) begin
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        txn(1'b0, d, f, lat);
        chk("rnd_fwd", f, ref_mix(d, 1'b0));
        txn(1'b1, f, r, lat);
        chk("rnd_trip", r, d);
      end
    end

    // reset two cycles into a C=1 transaction
    sel = 2;
    send(1'b0, 128'hcafef00d_deadbeef_01234567_89abcdef);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(out_valid_m), 128'(0));
    chk("mid_rst_data", data_out_m, 128'(0));
    chk("mid_rst_busy", 128'(busy_m), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 128'(in_ready_m), 128'(1));
    flag = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid_m) flag = 1'b1;
    end
    chk("mid_rst_spurious", 128'(flag), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
